punc_control: RTL

Control unit for the PUnC LC3 processor: a fetch/decode/execute state machine that reads the instruction register and condition codes from the datapath and drives every datapath select, load and write-enable each cycle. Together with the datapath it forms the complete processor. It issues the control side of the datapath's select/load interface and consumes the status side.

---
 rtl/punc_control_pkg.sv | 71 +++++++
 rtl/punc_control.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/punc_control_pkg.sv
// punc_control_pkg
// Shared constants for the PUnC LC3 control unit: opcodes, datapath select
// encodings, FSM state encoding, and small decode helpers.
package punc_control_pkg;

    // Opcodes, ir[15:12]
    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // PC load source
    localparam logic PC_DATA_ADDER = 1'b0;
    localparam logic PC_DATA_ALU   = 1'b1;

    // PC adder offset
    localparam logic PC_ADD_OFF11 = 1'b0;
    localparam logic PC_ADD_OFF9  = 1'b1;

    // Memory address source
    localparam logic [1:0] ADDR_PC    = 2'b00;
    localparam logic [1:0] ADDR_ALU   = 2'b01;
    localparam logic [1:0] ADDR_STORE = 2'b10;

    // RF write data source
    localparam logic [1:0] W_RF_PC  = 2'b00;
    localparam logic [1:0] W_RF_MEM = 2'b01;
    localparam logic [1:0] W_RF_ALU = 2'b10;

    // ALU operand sources
    localparam logic A_PC   = 1'b0;
    localparam logic A_RF   = 1'b1;
    localparam logic B_RF   = 1'b0;
    localparam logic B_SEXT = 1'b1;

    // ALU operations
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_AND    = 2'b01;
    localparam logic [1:0] ALU_PASS_A = 2'b10;
    localparam logic [1:0] ALU_NOT    = 2'b11;

    // Condition-code source
    localparam logic NZP_ALU = 1'b0;
    localparam logic NZP_MEM = 1'b1;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_EXEC2  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    function automatic logic branch_taken(input logic [2:0] nzp_mask,
                                          input logic n, input logic z,
                                          input logic p);
        return (nzp_mask[2] & n) | (nzp_mask[1] & z) | (nzp_mask[0] & p);
    endfunction

endpackage

// File: rtl/punc_control.sv
// punc_control
// Fetch/decode/execute controller for the PUnC LC3 datapath.
// Inputs : clk, rst (sync, active-high), ir[15:0], n/z/p condition codes.
// Outputs: every datapath select, load and write enable, sext_data to ALU B,
//          and halted. All outputs decode combinationally from state and ir
//          (BR additionally looks at n/z/p) and are forced to 0 during rst.
//
// state  | meaning
// INIT   | clear PC after reset
// FETCH  | read mem[PC] into IR, increment PC
// DECODE | idle cycle while IR settles
// EXEC   | execute instruction (first access for LDI/STI)
// EXEC2  | indirect access through store register (LDI/STI)
// HALT   | stopped until rst
module punc_control
    import punc_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    output logic        PC_data_sel,
    output logic        PC_add_sel,
    output logic        PC_ld,
    output logic        PC_clr,
    output logic        PC_inc,
    output logic        IR_ld,
    output logic [1:0]  addr_MEM_sel,
    output logic        w_en_MEM,
    output logic [1:0]  w_RF_sel,
    output logic [2:0]  r_addr_0_RF,
    output logic [2:0]  r_addr_1_RF,
    output logic [2:0]  w_addr_RF,
    output logic        w_en_RF,
    output logic [15:0] sext_data,
    output logic        A_sel,
    output logic        B_sel,
    output logic [1:0]  ALU_sel,
    output logic        NZP_sel,
    output logic        N_ld,
    output logic        Z_ld,
    output logic        P_ld,
    output logic        store_ld,
    output logic        halted
);

    state_t state;

    logic [3:0]  opcode;
    logic [15:0] sext5;
    logic [15:0] sext6;
    logic [15:0] sext9;
    logic        nzp_ld;

    assign opcode = ir[15:12];
    assign sext5  = {{11{ir[4]}}, ir[4:0]};
    assign sext6  = {{10{ir[5]}}, ir[5:0]};
    assign sext9  = {{7{ir[8]}},  ir[8:0]};

    // The three condition-code loads are never used independently.
    assign N_ld = nzp_ld;
    assign Z_ld = nzp_ld;
    assign P_ld = nzp_ld;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            case (state)
                S_INIT:   state <= S_FETCH;
                S_FETCH:  state <= S_DECODE;
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    if (opcode == OP_LDI || opcode == OP_STI) state <= S_EXEC2;
                    else if (opcode == OP_HALT)               state <= S_HALT;
                    else                                      state <= S_FETCH;
                end
                S_EXEC2:  state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_INIT;
            endcase
        end
    end

    always_comb begin
        PC_data_sel  = PC_DATA_ADDER;
        PC_add_sel   = PC_ADD_OFF11;
        PC_ld        = 1'b0;
        PC_clr       = 1'b0;
        PC_inc       = 1'b0;
        IR_ld        = 1'b0;
        addr_MEM_sel = ADDR_PC;
        w_en_MEM     = 1'b0;
        w_RF_sel     = W_RF_PC;
        r_addr_0_RF  = 3'd0;
        r_addr_1_RF  = 3'd0;
        w_addr_RF    = 3'd0;
        w_en_RF      = 1'b0;
        sext_data    = 16'h0000;
        A_sel        = A_PC;
        B_sel        = B_RF;
        ALU_sel      = ALU_ADD;
        NZP_sel      = NZP_ALU;
        nzp_ld       = 1'b0;
        store_ld     = 1'b0;
        halted       = 1'b0;

        if (!rst) begin
            case (state)
                S_INIT: PC_clr = 1'b1;
                S_FETCH: begin
                    addr_MEM_sel = ADDR_PC;
                    IR_ld        = 1'b1;
                    PC_inc       = 1'b1;
                end
                S_EXEC: begin
                    case (opcode)
                        OP_ADD, OP_AND: begin
                            ALU_sel     = (opcode == OP_ADD) ? ALU_ADD : ALU_AND;
                            A_sel       = A_RF;
                            r_addr_0_RF = ir[8:6];
                            r_addr_1_RF = ir[2:0];
                            B_sel       = ir[5] ? B_SEXT : B_RF;
                            sext_data   = sext5;
                            w_RF_sel    = W_RF_ALU;
                            w_addr_RF   = ir[11:9];
                            w_en_RF     = 1'b1;
                            nzp_ld      = 1'b1;
                        end
                        OP_NOT: begin
                            ALU_sel     = ALU_NOT;
                            A_sel       = A_RF;
                            r_addr_0_RF = ir[8:6];
                            w_RF_sel    = W_RF_ALU;
                            w_addr_RF   = ir[11:9];
                            w_en_RF     = 1'b1;
                            nzp_ld      = 1'b1;
                        end
                        OP_BR: begin
                            PC_data_sel = PC_DATA_ADDER;
                            PC_add_sel  = PC_ADD_OFF9;
                            PC_ld       = branch_taken(ir[11:9], n, z, p);
                        end
                        OP_JMP: begin
                            A_sel       = A_RF;
                            r_addr_0_RF = ir[8:6];
                            ALU_sel     = ALU_PASS_A;
                            PC_data_sel = PC_DATA_ALU;
                            PC_ld       = 1'b1;
                        end
                        OP_JSR: begin
                            // R7 is written at the clock edge, so JSRR R7
                            // reads the old link value this cycle.
                            w_RF_sel  = W_RF_PC;
                            w_addr_RF = 3'd7;
                            w_en_RF   = 1'b1;
                            PC_ld     = 1'b1;
                            if (ir[11]) begin
                                PC_data_sel = PC_DATA_ADDER;
                                PC_add_sel  = PC_ADD_OFF11;
                            end else begin
                                A_sel       = A_RF;
                                r_addr_0_RF = ir[8:6];
                                ALU_sel     = ALU_PASS_A;
                                PC_data_sel = PC_DATA_ALU;
                            end
                        end
                        OP_LD, OP_LDR: begin
                            A_sel        = (opcode == OP_LDR) ? A_RF : A_PC;
                            r_addr_0_RF  = ir[8:6];
                            B_sel        = B_SEXT;
                            sext_data    = (opcode == OP_LDR) ? sext6 : sext9;
                            ALU_sel      = ALU_ADD;
                            addr_MEM_sel = ADDR_ALU;
                            w_RF_sel     = W_RF_MEM;
                            w_addr_RF    = ir[11:9];
                            w_en_RF      = 1'b1;
                            NZP_sel      = NZP_MEM;
                            nzp_ld       = 1'b1;
                        end
                        OP_LEA: begin
                            A_sel     = A_PC;
                            B_sel     = B_SEXT;
                            sext_data = sext9;
                            ALU_sel   = ALU_ADD;
                            w_RF_sel  = W_RF_ALU;
                            w_addr_RF = ir[11:9];
                            w_en_RF   = 1'b1;
                        end
                        OP_ST, OP_STR: begin
                            A_sel        = (opcode == OP_STR) ? A_RF : A_PC;
                            r_addr_0_RF  = ir[8:6];
                            B_sel        = B_SEXT;
                            sext_data    = (opcode == OP_STR) ? sext6 : sext9;
                            ALU_sel      = ALU_ADD;
                            addr_MEM_sel = ADDR_ALU;
                            r_addr_1_RF  = ir[11:9];
                            w_en_MEM     = 1'b1;
                        end
                        OP_LDI, OP_STI: begin
                            A_sel        = A_PC;
                            B_sel        = B_SEXT;
                            sext_data    = sext9;
                            ALU_sel      = ALU_ADD;
                            addr_MEM_sel = ADDR_ALU;
                            store_ld     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_EXEC2: begin
                    addr_MEM_sel = ADDR_STORE;
                    if (opcode == OP_LDI) begin
                        w_RF_sel  = W_RF_MEM;
                        w_addr_RF = ir[11:9];
                        w_en_RF   = 1'b1;
                        NZP_sel   = NZP_MEM;
                        nzp_ld    = 1'b1;
                    end else begin
                        r_addr_1_RF = ir[11:9];
                        w_en_MEM    = 1'b1;
                    end
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
